// File: rtl/key_event_pkg.sv
// Shared types for the keycode event queue: event record, FSM states, no-key code.
package key_event_pkg;

   localparam logic [7:0] KEY_NONE = 8'h00;

   typedef struct packed {
      logic       press;
      logic [7:0] code;
   } key_event_t;

   typedef enum logic [1:0] {
      IDLE,
      HELD,
      SWAP
   } key_state_e;

endpackage

// File: rtl/keycode_event_queue_if.sv
// Keycode input, consumer pop and head-of-queue event outputs.
// The slave modport is the queue itself; the master is the SoC/consumer side.
interface keycode_event_queue_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [7:0]    keycode;
   logic          pop;
   logic          event_valid;
   logic [7:0]    event_code;
   logic          event_press;
   logic [CW-1:0] count;
   logic          overflow;

   modport master (
      output keycode, pop,
      input  event_valid, event_code, event_press, count, overflow
   );

   modport slave (
      input  keycode, pop,
      output event_valid, event_code, event_press, count, overflow
   );
endinterface

// File: rtl/key_event_fifo.sv
// Show-ahead FIFO of key events; head visible combinationally when not empty.
// Push into a full FIFO succeeds only if a pop happens in the same cycle.
module key_event_fifo
   import key_event_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  key_event_t             data_i,
   input  logic                   pop_i,
   output key_event_t             data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);

   key_event_t    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   // Output is forced to zero when empty so stale storage never leaks out.
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/keycode_event_queue.sv
// Filters the raw keycode for stability and queues press/release events.
// Press is pushed STABLE_CYCLES edges after the registering edge; a swap adds one edge.
module keycode_event_queue
   import key_event_pkg::*;
#(
   parameter int DEPTH         = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  Clk,
   input  logic                  Reset,
   keycode_event_queue_if.slave  bus
);
   localparam int               CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] SC    = CNT_W'(STABLE_CYCLES);

   logic [7:0]       keycode_q;
   logic [7:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       accepted_q, accepted_d;
   logic [7:0]       pending_q, pending_d;
   key_state_e       state_q, state_d;
   logic             overflow_q, overflow_d;
   logic             stable;
   logic             push;
   key_event_t       push_ev, head;
   logic             full, empty;

   // Stability is judged on next-state filter values so the push lands on the
   // same edge the counter reaches STABLE_CYCLES.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (keycode_q != cand_q) begin
         cand_d = keycode_q;
         cnt_d  = CNT_W'(1);
      end else if (cnt_q != SC) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      stable = (cnt_d == SC) && (cand_d != accepted_q);
   end

   always_comb begin
      state_d    = state_q;
      accepted_d = accepted_q;
      pending_d  = pending_q;
      push       = 1'b0;
      push_ev    = '0;
      unique case (state_q)
         IDLE: begin
            if (stable && cand_d != KEY_NONE) begin
               push       = 1'b1;
               push_ev    = '{press: 1'b1, code: cand_d};
               accepted_d = cand_d;
               state_d    = HELD;
            end
         end
         HELD: begin
            if (stable) begin
               push    = 1'b1;
               push_ev = '{press: 1'b0, code: accepted_q};
               if (cand_d == KEY_NONE) begin
                  accepted_d = KEY_NONE;
                  state_d    = IDLE;
               end else begin
                  pending_d = cand_d;
                  state_d   = SWAP;
               end
            end
         end
         SWAP: begin
            push       = 1'b1;
            push_ev    = '{press: 1'b1, code: pending_q};
            accepted_d = pending_q;
            state_d    = HELD;
         end
         default: state_d = IDLE;
      endcase
   end

   assign overflow_d = overflow_q || (push && full && !bus.pop);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         keycode_q  <= KEY_NONE;
         cand_q     <= KEY_NONE;
         cnt_q      <= '0;
         accepted_q <= KEY_NONE;
         pending_q  <= KEY_NONE;
         state_q    <= IDLE;
         overflow_q <= 1'b0;
      end else begin
         keycode_q  <= bus.keycode;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         accepted_q <= accepted_d;
         pending_q  <= pending_d;
         state_q    <= state_d;
         overflow_q <= overflow_d;
      end
   end

   key_event_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .push_i  (push),
      .data_i  (push_ev),
      .pop_i   (bus.pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (bus.count)
   );

   assign bus.event_valid = !empty;
   assign bus.event_code  = head.code;
   assign bus.event_press = head.press;
   assign bus.overflow    = overflow_q;
endmodule
